// File: rtl/relm_div_seq.sv
// relm_div_seq -- hardware initiator for the ReLM custom divide unit.
//
// This block replaces the software DIV / DIVINIT / DIVLOOP sequence. It takes an
// unsigned N/D pair on a valid/ready request port and steps the combinational divide
// unit through its sub-ops. It then returns the quotient, the remainder and a
// divide-by-zero flag on a valid/ready response port.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   req_valid/req_ready      request handshake; ready only while idle
//   req_n, req_d             numerator / divisor (unsigned)
//   rsp_valid/rsp_ready      response handshake; rsp_* held until accepted
//   rsp_q, rsp_r, rsp_dz     quotient, remainder, divide-by-zero flag
//   cu_op, cu_opb, cu_x,     operand/op ports driven into the divide unit
//   cu_xb, cu_a, cu_cb       (cu_x carries the sub-op in bits [WOP+1:WOP])
//   cu_a_rd, cu_cb_rd        results returned by the divide unit
//   cu_retry                 unit stall: hold all cu_* and state, capture nothing
//
// Unit result mapping used by the sequencer (cb = {D field, C field, B field}):
//   DIV     : a_rd = one-hot MSB(N), cb_rd.D = one-hot MSB(D), cb_rd.C = N
//   DIVINIT : cb_rd.D = quotient bit pointer q, cb_rd.C = running remainder
//   DIVLOOP : a_rd = next shifted divisor, cb_rd = {next q pointer, remainder, quotient}
//
// Configuration macro: RELM_DIV_SEQ_REGOUT_EN
//   When this macro is defined, cu_a_rd and cu_cb_rd are registered before use. Each
//   unit step then takes two cycles: the first cycle issues the op and the second
//   cycle uses the registered result. The results do not change.
module relm_div_seq #(
    parameter int WD  = 32,
    parameter int WOP = 5,
    parameter int WC  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WD-1:0]    req_n,
    input  logic [WD-1:0]    req_d,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WD-1:0]    rsp_q,
    output logic [WD-1:0]    rsp_r,
    output logic             rsp_dz,
    output logic [WOP-1:0]   cu_op,
    output logic             cu_opb,
    output logic [WD-1:0]    cu_x,
    output logic [WD-1:0]    cu_xb,
    output logic [WD-1:0]    cu_a,
    output logic [WC+WD-1:0] cu_cb,
    input  logic [WD-1:0]    cu_a_rd,
    input  logic [WC+WD-1:0] cu_cb_rd,
    input  logic             cu_retry
);

    localparam int KW = $clog2(WD);
    localparam logic [1:0] SUB_DIV  = 2'b00;
    localparam logic [1:0] SUB_INIT = 2'b01;
    localparam logic [1:0] SUB_LOOP = 2'b10;

    typedef enum logic [2:0] {S_IDLE, S_DIV, S_INIT, S_LOOP, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [WD-1:0]     d_reg;
    logic [KW-1:0]     k_q;
    logic [WD-1:0]     a_use;
    logic [WC+WD-1:0]  cb_use;
    logic              unit_active, step;
    logic [WD-1:0]     n1, d1;
    logic [KW-1:0]     k_new;
    logic              short_path, loop_done;

    // Bit index of the single set bit in a one-hot word.
    function automatic logic [KW-1:0] oh_idx(input logic [WD-1:0] v);
        oh_idx = '0;
        for (int i = 0; i < WD; i++)
            if (v[i]) oh_idx = KW'(i);
    endfunction

    function automatic logic [WD-1:0] sub_x(input logic [1:0] s);
        sub_x = '0;
        sub_x[WOP+1:WOP] = s;
    endfunction

    assign cu_op = WOP'(3'b101);
    assign unit_active = (state_q == S_DIV) || (state_q == S_INIT) || (state_q == S_LOOP);

`ifdef RELM_DIV_SEQ_REGOUT_EN
    logic             phase;
    logic [WD-1:0]    a_rd_q;
    logic [WC+WD-1:0] cb_rd_q;

    // phase 0 issues the op and registers the unit result; phase 1 consumes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase   <= 1'b0;
            a_rd_q  <= '0;
            cb_rd_q <= '0;
        end else if (unit_active && !cu_retry) begin
            if (!phase) begin
                a_rd_q  <= cu_a_rd;
                cb_rd_q <= cu_cb_rd;
            end
            phase <= ~phase;
        end
    end

    assign a_use  = a_rd_q;
    assign cb_use = cb_rd_q;
    assign step   = unit_active && phase && !cu_retry;
`else
    assign a_use  = cu_a_rd;
    assign cb_use = cu_cb_rd;
    assign step   = unit_active && !cu_retry;
`endif

    // DIV returns one-hot MSBs. When the numerator MSB sits below the divisor MSB the
    // quotient is zero and the INIT/LOOP phases are skipped.
    assign n1         = a_use;
    assign d1         = cb_use[WC+WD-1 -: WD];
    assign short_path = n1 < d1;
    assign k_new      = oh_idx(n1) - oh_idx(d1);
    assign loop_done  = (cb_use[WC+WD-1 -: WD] == '0);

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path leaves a value
    // unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = (req_d == '0) ? S_RESP : S_DIV;
            end
            S_DIV:  if (step) state_d = short_path ? S_RESP : S_INIT;
            S_INIT: if (step) state_d = S_LOOP;
            S_LOOP: if (step && loop_done) state_d = S_RESP;
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: registered state is written with non-blocking assignments. All flops then
    // update together at the edge, and later statements here see the old values.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_reg  <= '0;
            k_q    <= '0;
            rsp_q  <= '0;
            rsp_r  <= '0;
            rsp_dz <= 1'b0;
            cu_opb <= 1'b0;
            cu_x   <= '0;
            cu_xb  <= '0;
            cu_a   <= '0;
            cu_cb  <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: if (req_valid) begin
                    d_reg <= req_d;
                    if (req_d == '0) begin
                        rsp_q  <= '1;
                        rsp_r  <= req_n;
                        rsp_dz <= 1'b1;
                    end else begin
                        cu_opb <= 1'b1;
                        cu_x   <= sub_x(SUB_DIV);
                        cu_a   <= req_n;
                        cu_xb  <= req_d;
                        cu_cb  <= '0;
                    end
                end
                S_DIV: if (step) begin
                    if (short_path) begin
                        rsp_q  <= '0;
                        rsp_r  <= cu_a;         // cu_a still carries N
                        rsp_dz <= 1'b0;
                    end else begin
                        k_q   <= k_new;
                        cu_x  <= sub_x(SUB_INIT);
                        cu_a  <= WD'(1) << k_new;
                        cu_xb <= '0;
                        cu_cb <= cb_use;
                    end
                end
                S_INIT: if (step) begin
                    // D is aligned under N's MSB, so the shift cannot overflow. The quotient
                    // (B) field starts from zero.
                    cu_x  <= sub_x(SUB_LOOP);
                    cu_a  <= d_reg << k_q;
                    cu_cb <= {cb_use[WC+WD-1:WD], {WD{1'b0}}};
                end
                S_LOOP: if (step) begin
                    cu_a  <= a_use;
                    cu_cb <= cb_use;
                    if (loop_done) begin
                        rsp_q  <= cb_use[WD-1:0];
                        rsp_r  <= cb_use[2*WD-1 -: WD];
                        rsp_dz <= 1'b0;
                    end
                end
                default: ;
            endcase
            // The unit is left idle while a result is pending or the block is idle.
            if (state_d == S_RESP && state_q != S_RESP) begin
                cu_opb <= 1'b0;
                cu_x   <= '0;
                cu_xb  <= '0;
                cu_a   <= '0;
                cu_cb  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_relm_div_seq.sv
// Testbench for relm_div_seq.
// A behavioural stand-in models the combinational divide unit. The reference results
// come from plain arithmetic (N/D, N%D), and the latency comes from the MSB distance
// between N and D.
module tb_relm_div_seq;

`ifdef RELM_DIV_SEQ_REGOUT_EN
    localparam int U = 2;
`else
    localparam int U = 1;
`endif

    logic        clk, rst;
    logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_dz;
    logic [31:0] req_n, req_d, rsp_q, rsp_r;
    logic [4:0]  cu_op;
    logic        cu_opb, cu_retry;
    logic [31:0] cu_x, cu_xb, cu_a, cu_a_rd;
    logic [95:0] cu_cb, cu_cb_rd;

    relm_div_seq dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_n(req_n), .req_d(req_d),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_dz(rsp_dz),
        .cu_op(cu_op), .cu_opb(cu_opb), .cu_x(cu_x), .cu_xb(cu_xb), .cu_a(cu_a), .cu_cb(cu_cb),
        .cu_a_rd(cu_a_rd), .cu_cb_rd(cu_cb_rd), .cu_retry(cu_retry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- divide-unit stand-in ----------------
    function automatic logic [31:0] onehot_msb(input logic [31:0] v);
        onehot_msb = '0;
        for (int i = 0; i < 32; i++) if (v[i]) onehot_msb = 32'd1 << i;
    endfunction

    function automatic logic [127:0] unit_eval(input logic opb, input logic [31:0] x, a, xb,
                                               input logic [95:0] cb);
        logic [31:0] dq, db, c, b;
        unit_eval = '0;
        if (opb) begin
            case (x[6:5])
                2'b00: unit_eval = {onehot_msb(a), onehot_msb(xb), a, xb};
                2'b01: unit_eval = {32'd0, a, cb[63:32], cb[31:0]};
                2'b10: begin
                    dq = a; db = cb[95:64]; c = cb[63:32]; b = cb[31:0];
                    for (int i = 0; i < 3; i++) begin
                        if (db != 0 && c >= dq) begin
                            c = c - dq;
                            b = b | db;
                        end
                        dq = dq >> 1;
                        db = db >> 1;
                    end
                    unit_eval = {dq, db, c, b};
                end
                default: unit_eval = '0;
            endcase
        end
    endfunction

    always_comb {cu_a_rd, cu_cb_rd} = unit_eval(cu_opb, cu_x, cu_a, cu_xb, cu_cb);

    // ---------------- reference model ----------------
    function automatic int msb(input logic [31:0] v);
        msb = -1;
        for (int i = 0; i < 32; i++) if (v[i]) msb = i;
    endfunction

    function automatic int exp_lat(input logic [31:0] n, input logic [31:0] d);
        if (d == 0) return 1;
        if (msb(n) < msb(d)) return 1 + U;
        return 1 + U * (2 + (msb(n) - msb(d)) / 3 + 1);
    endfunction

    typedef struct {
        logic [31:0] n, d, q, r;
        logic        dz;
        int          lat;
        longint      acc;
    } exp_t;

    exp_t exp_q[$];
    int   exp_extra = 0;

    // ---------------- compare process ----------------
    logic         prev_rst = 1'b0, prev_retry = 1'b0, seen = 1'b0;
    logic [224:0] snap;
    always @(negedge clk) begin
        exp_t e;
        logic [31:0] recon;
        if (rst) begin
            exp_q.delete();
            seen = 1'b0;
        end else begin
            if (prev_rst) begin
                check("rst_req_ready", req_ready, 1);
                check("rst_rsp_valid", rsp_valid, 0);
                check("rst_rsp_qrdz", {rsp_q, rsp_r, rsp_dz}, 0);
                check("rst_cu_regs", {cu_opb, cu_x, cu_xb, cu_a, cu_cb}, 0);
            end
            check("cu_op_const", cu_op, 5'b00101);
            if (prev_retry) check("retry_hold", {cu_opb, cu_x, cu_xb, cu_a, cu_cb}, snap);
            if (rsp_valid) begin
                check("req_ready_busy", req_ready, 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 expected 0 (t=%0t)", $time);
                end else begin
                    e = exp_q[0];
                    if (!seen) begin
                        check("latency", 128'(cyc - e.acc), 128'(e.lat));
                        seen = 1'b1;
                    end
                    check("rsp_q", rsp_q, e.q);
                    check("rsp_r", rsp_r, e.r);
                    check("rsp_dz", rsp_dz, e.dz);
                    if (e.d != 0) begin
                        recon = rsp_q * e.d + rsp_r;
                        check("inv_qd_plus_r", recon, e.n);
                        check("inv_r_lt_d", rsp_r < e.d, 1);
                    end
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        seen = 1'b0;
                    end
                end
            end
            if (req_valid && req_ready) begin
                e.n   = req_n;
                e.d   = req_d;
                e.q   = (req_d == 0) ? 32'hFFFF_FFFF : req_n / req_d;
                e.r   = (req_d == 0) ? req_n : req_n % req_d;
                e.dz  = (req_d == 0);
                e.lat = exp_lat(req_n, req_d) + exp_extra;
                e.acc = cyc;
                exp_q.push_back(e);
            end
        end
        prev_rst   = rst;
        prev_retry = cu_retry;
        snap       = {cu_opb, cu_x, cu_xb, cu_a, cu_cb};
    end

    // ---------------- driver ----------------
    task automatic run_op(input logic [31:0] n, input logic [31:0] d, input int hold,
                          input int retry_at);
        int t;
        @(posedge clk); #1;
        exp_extra = (retry_at >= 0) ? 3 : 0;
        req_n = n; req_d = d; req_valid = 1'b1; rsp_ready = 1'b0;
        t = 0;
        while (!req_ready && t < 100) begin @(posedge clk); #1; t++; end
        if (t >= 100) begin
            checks++; errors++;
            $display("FAIL req_timeout: got no req_ready expected ready within 100 cycles");
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        t = 1;
        while (!rsp_valid && t < 200) begin
            cu_retry = (retry_at >= 0) && (t >= retry_at) && (t < retry_at + 3);
            @(posedge clk); #1;
            t++;
        end
        cu_retry = 1'b0;
        if (t >= 200) begin
            checks++; errors++;
            $display("FAIL rsp_timeout: got no rsp_valid expected it within 200 cycles");
        end
        repeat (hold) begin @(posedge clk); #1; end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        exp_extra = 0;
    endtask

    initial begin
        logic [31:0] rn, rd;
        rst = 1'b1; req_valid = 1'b0; req_n = '0; req_d = '0; rsp_ready = 1'b0; cu_retry = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Hand-computed values that pin the reference model.
        check("pin_lat_100_7", exp_lat(100, 7), (U == 1) ? 5 : 9);
        check("pin_lat_max", exp_lat(32'hFFFF_FFFF, 1), (U == 1) ? 14 : 27);
        check("pin_lat_5_9", exp_lat(5, 9), (U == 1) ? 2 : 3);
        check("pin_lat_dz", exp_lat(9, 0), 1);

        run_op(32'd100, 32'd7, 0, -1);
        run_op(32'hFFFF_FFFF, 32'd1, 0, -1);
        run_op(32'd5, 32'd9, 0, -1);
        run_op(32'd9, 32'd0, 0, -1);
        run_op(32'd1000, 32'd3, 0, (U == 1) ? 4 : 6);
        run_op(32'd100, 32'd7, 4, -1);
        run_op(32'd0, 32'd5, 1, -1);
        run_op(32'd7, 32'd7, 0, -1);
        run_op(32'd12, 32'd9, 0, -1);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, -1);

        // Reset pulse mid-LOOP: the pending result is discarded.
        @(posedge clk); #1;
        req_n = 32'hFFFF_FFFF; req_d = 32'd1; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3 * U + 2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);

        for (int i = 0; i < 1500; i++) begin
            rd = $urandom >> $urandom_range(0, 31);
            if (rd == 0) rd = 32'd1;
            rn = $urandom >> $urandom_range(0, 8);
            run_op(rn, rd, $urandom_range(0, 2), -1);
        end

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL pending_at_end: got %0d outstanding expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
